// File: rtl/hex_word_ascii_tx.sv
// Serializes one DATA_W-bit word into ASCII hex text ("0x", digits MSB first, CR LF), one byte per handshake.
// Latency: first character valid the cycle after the word is accepted; one character per cycle when out_ready is high.
// Backpressure: out_valid && !out_ready freezes state and holds out_char/out_last; new words only accepted in IDLE.
module hex_word_ascii_tx #(
    parameter int DATA_W     = 32,
    parameter int LOWER_CASE = 0,
    parameter int PREFIX_EN  = 1,
    parameter int EOL_EN     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_char,
    output logic              out_last,
    output logic              busy
);

    localparam int NDIG = DATA_W / 4;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    // The last digit carries out_last only when no CR/LF follows it.
    localparam logic DIGIT_ENDS_WORD = (EOL_EN == 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PFX0,
        S_PFX1,
        S_DIGIT,
        S_CR,
        S_LF
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] sr;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] sr_shl;
    logic              consume;

    // Nibble to ASCII; 'A' - 10 = 8'h37, 'a' - 10 = 8'h57.
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end else if (LOWER_CASE != 0) begin
            return 8'h57 + {4'h0, n};
        end else begin
            return 8'h37 + {4'h0, n};
        end
    endfunction

    assign sr_shl   = sr << 4;
    assign consume  = out_valid && out_ready;
    assign in_ready = (state == S_IDLE) && !rst;
    assign busy     = (state != S_IDLE);

    // Character FSM: state names the character currently presented on out_char.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            sr        <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_char  <= 8'h00;
            out_last  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        sr        <= in_data;
                        cnt       <= CW'(NDIG - 1);
                        out_valid <= 1'b1;
                        if (PREFIX_EN != 0) begin
                            state    <= S_PFX0;
                            out_char <= 8'h30;
                            out_last <= 1'b0;
                        end else begin
                            state    <= S_DIGIT;
                            out_char <= hex_char(in_data[DATA_W-1 -: 4]);
                            out_last <= (NDIG == 1) && DIGIT_ENDS_WORD;
                        end
                    end
                end
                S_PFX0: begin
                    if (consume) begin
                        state    <= S_PFX1;
                        out_char <= 8'h78;
                    end
                end
                S_PFX1: begin
                    if (consume) begin
                        state    <= S_DIGIT;
                        out_char <= hex_char(sr[DATA_W-1 -: 4]);
                        out_last <= (NDIG == 1) && DIGIT_ENDS_WORD;
                    end
                end
                S_DIGIT: begin
                    if (consume) begin
                        sr <= sr_shl;
                        if (cnt == CW'(0)) begin
                            if (EOL_EN != 0) begin
                                state    <= S_CR;
                                out_char <= 8'h0D;
                                out_last <= 1'b0;
                            end else begin
                                state     <= S_IDLE;
                                out_valid <= 1'b0;
                                out_char  <= 8'h00;
                                out_last  <= 1'b0;
                            end
                        end else begin
                            cnt      <= cnt - CW'(1);
                            out_char <= hex_char(sr_shl[DATA_W-1 -: 4]);
                            out_last <= (cnt == CW'(1)) && DIGIT_ENDS_WORD;
                        end
                    end
                end
                S_CR: begin
                    if (consume) begin
                        state    <= S_LF;
                        out_char <= 8'h0A;
                        out_last <= 1'b1;
                    end
                end
                S_LF: begin
                    if (consume) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        out_char  <= 8'h00;
                        out_last  <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                    out_char  <= 8'h00;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_word_ascii_tx.sv
// Bench for hex_word_ascii_tx: default 32-bit instance plus an 8-bit lower-case instance without prefix/EOL.
module tb_hex_word_ascii_tx;

    logic        clk;
    logic        rst0, in_valid0, in_ready0, out_valid0, out_ready0, out_last0, busy0;
    logic [31:0] in_data0;
    logic [7:0]  out_char0;

    logic        rst1, in_valid1, in_ready1, out_valid1, out_ready1, out_last1, busy1;
    logic [7:0]  in_data1;
    logic [7:0]  out_char1;

    int n_chk  = 0;
    int n_fail = 0;

    logic [8:0] q0[$];
    logic [8:0] q1[$];

    hex_word_ascii_tx u0 (
        .clk(clk), .rst(rst0), .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_char(out_char0), .out_last(out_last0),
        .busy(busy0)
    );

    hex_word_ascii_tx #(.DATA_W(8), .LOWER_CASE(1), .PREFIX_EN(0), .EOL_EN(0)) u1 (
        .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_char(out_char1), .out_last(out_last1),
        .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n, input bit lower);
        if (n < 4'd10) return 8'h30 + 8'(n);
        return (lower ? 8'h61 : 8'h41) + 8'(n) - 8'd10;
    endfunction

    task automatic push0(input logic [31:0] d);
        q0.push_back({1'b0, 8'h30});
        q0.push_back({1'b0, 8'h78});
        for (int i = 7; i >= 0; i--) q0.push_back({1'b0, hexc(d[i*4 +: 4], 1'b0)});
        q0.push_back({1'b0, 8'h0D});
        q0.push_back({1'b1, 8'h0A});
    endtask

    task automatic push1(input logic [7:0] d);
        q1.push_back({1'b0, hexc(d[7:4], 1'b1)});
        q1.push_back({1'b1, hexc(d[3:0], 1'b1)});
    endtask

    task automatic send0(input logic [31:0] d);
        int t = 0;
        while (!in_ready0 && t < 100) begin @(posedge clk); #1; t++; end
        chk("send0_ready_timeout", 32'(t >= 100), 32'd0);
        in_data0 = d; in_valid0 = 1'b1; push0(d);
        @(posedge clk); #1;
        in_valid0 = 1'b0;
    endtask

    task automatic send1(input logic [7:0] d);
        int t = 0;
        while (!in_ready1 && t < 100) begin @(posedge clk); #1; t++; end
        chk("send1_ready_timeout", 32'(t >= 100), 32'd0);
        in_data1 = d; in_valid1 = 1'b1; push1(d);
        @(posedge clk); #1;
        in_valid1 = 1'b0;
    endtask

    task automatic wait_idle0();
        int t = 0;
        while ((q0.size() != 0 || !in_ready0) && t < 500) begin @(posedge clk); #1; t++; end
        chk("idle0_timeout", 32'(t >= 500), 32'd0);
    endtask

    task automatic wait_idle1();
        int t = 0;
        while ((q1.size() != 0 || !in_ready1) && t < 500) begin @(posedge clk); #1; t++; end
        chk("idle1_timeout", 32'(t >= 500), 32'd0);
    endtask

    // Scoreboard for u0: pop on each handshake, check stall stability.
    initial begin
        bit         stall = 1'b0;
        logic [7:0] pchar = 8'h00;
        logic       plast = 1'b0;
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (rst0) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    chk("stall_char0", 32'(out_char0), 32'(pchar));
                    chk("stall_last0", 32'(out_last0), 32'(plast));
                end
                if (out_valid0 && out_ready0) begin
                    if (q0.size() == 0) begin
                        chk("unexpected_char0", 32'(out_char0), 32'hFFFF_FFFF);
                    end else begin
                        e = q0.pop_front();
                        chk("char0", 32'(out_char0), 32'(e[7:0]));
                        chk("last0", 32'(out_last0), 32'(e[8]));
                    end
                end
                stall = out_valid0 && !out_ready0;
                pchar = out_char0;
                plast = out_last0;
            end
        end
    end

    // Scoreboard for u1.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (!rst1 && out_valid1 && out_ready1) begin
                if (q1.size() == 0) begin
                    chk("unexpected_char1", 32'(out_char1), 32'hFFFF_FFFF);
                end else begin
                    e = q1.pop_front();
                    chk("char1", 32'(out_char1), 32'(e[7:0]));
                    chk("last1", 32'(out_last1), 32'(e[8]));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         n;
        int         k;
        int         w;
        logic [3:0] pat;

        pat        = 4'b1001;
        rst0       = 1'b1; rst1 = 1'b1;
        in_valid0  = 1'b1; in_data0 = 32'hDEADBEEF; out_ready0 = 1'b1;
        in_valid1  = 1'b0; in_data1 = 8'h00;        out_ready1 = 1'b1;

        // Reset state, with in_valid asserted to confirm it is not accepted.
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("rst_in_ready0", 32'(in_ready0), 32'd0);
        chk("rst_out_valid0", 32'(out_valid0), 32'd0);
        chk("rst_out_char0", 32'(out_char0), 32'h00);
        chk("rst_out_last0", 32'(out_last0), 32'd0);
        chk("rst_busy0", 32'(busy0), 32'd0);
        chk("rst_in_ready1", 32'(in_ready1), 32'd0);
        @(posedge clk); #1;
        rst0 = 1'b0; rst1 = 1'b0; in_valid0 = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready0", 32'(in_ready0), 32'd1);
        chk("post_rst_busy0", 32'(busy0), 32'd0);
        chk("post_rst_out_valid0", 32'(out_valid0), 32'd0);
        @(posedge clk); #1;

        // 1: DEADBEEF at full rate, 12 chars in 12 cycles.
        send0(32'hDEADBEEF);
        @(negedge clk);
        chk("t1_latency_valid", 32'(out_valid0), 32'd1);
        chk("t1_busy", 32'(busy0), 32'd1);
        chk("t1_in_ready_busy", 32'(in_ready0), 32'd0);
        n = 0;
        while (q0.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
        chk("t1_cycles", 32'(n), 32'd12);
        chk("t1_in_ready_after", 32'(in_ready0), 32'd1);
        chk("t1_valid_after", 32'(out_valid0), 32'd0);

        // 2: same word with out_ready pattern 1,0,0,1.
        send0(32'hDEADBEEF);
        k = 0;
        while (q0.size() != 0 && k < 400) begin
            out_ready0 = pat[k % 4];
            @(posedge clk); #1;
            k++;
        end
        out_ready0 = 1'b1;
        chk("t2_timeout", 32'(k >= 400), 32'd0);
        wait_idle0();

        // 3: 8-bit lower-case instance, no prefix, no EOL.
        send1(8'hAF);
        wait_idle1();
        send1(8'h09);
        wait_idle1();

        // 4: continuous in_valid across two words.
        in_data0 = 32'h00000001; in_valid0 = 1'b1; push0(32'h00000001);
        @(posedge clk); #1;
        in_data0 = 32'hFFFFFFFF; push0(32'hFFFFFFFF);
        w = 0;
        while (!in_ready0 && w < 100) begin @(posedge clk); #1; w++; end
        chk("t4_second_accept_wait", 32'(w), 32'd12);
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        wait_idle0();

        // 5: reset after the 4th character of 12345678.
        send0(32'h12345678);
        n = 0;
        while (q0.size() > 8 && n < 100) begin @(posedge clk); #1; n++; end
        rst0 = 1'b1;
        @(negedge clk);
        chk("t5_in_ready_in_rst", 32'(in_ready0), 32'd0);
        @(posedge clk); #1;
        rst0 = 1'b0;
        q0.delete();
        @(negedge clk);
        chk("t5_valid_after_rst", 32'(out_valid0), 32'd0);
        chk("t5_busy_after_rst", 32'(busy0), 32'd0);
        chk("t5_in_ready_after_rst", 32'(in_ready0), 32'd1);
        @(posedge clk); #1;
        send0(32'h00000000);
        wait_idle0();

        // 6: in_valid pulse while busy is ignored.
        send0(32'hDEADBEEF);
        repeat (3) begin @(posedge clk); #1; end
        chk("t6_busy", 32'(busy0), 32'd1);
        in_data0 = 32'hCAFEF00D; in_valid0 = 1'b1;
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        wait_idle0();
        repeat (3) begin @(posedge clk); #1; end
        chk("t6_no_extra_word", 32'(busy0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
